// File: rtl/sample_pacer_fifo.sv
// Sample FIFO that paces its output onto x at a fixed rate of one sample every DIV clocks.
// Latency: a sample pushed at edge N can leave at the first strobe edge at or after N+1; x is registered.
// Backpressure: in_ready = (level < DEPTH) from registered level only; a push offered while full is dropped and sets sticky overflow.
module sample_pacer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,  // power of two, >= 2
    parameter int DIV   = 4   // >= 1
) (
    input  logic                     CLOCK_50,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         x,
    output logic                     x_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underrun,
    input  logic                     clr_flags
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic [CW-1:0]    div_cnt;
    logic             primed;

    logic push;
    logic drop;
    logic strobe;
    logic pop;
    logic starved;

    // Handshake and pacing decisions all use registered state, so a pop never
    // frees a slot for the same cycle and a fresh push is never popped at once.
    always_comb begin
        in_ready = (level_q < FULL_LEVEL);
        push     = in_valid & in_ready;
        drop     = in_valid & ~in_ready;
        strobe   = (div_cnt == DIV_LAST);
        pop      = strobe & (level_q != '0);
        starved  = strobe & (level_q == '0) & primed;
    end

    assign level = level_q;

    // Sample storage; contents need no reset because level gates every read.
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge CLOCK_50) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Strobe divider: counts 0..DIV-1 and strobes on the last count.
    always_ff @(posedge CLOCK_50) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (strobe) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    // Output register: x loads the head on a productive strobe and otherwise holds.
    always_ff @(posedge CLOCK_50) begin
        if (!rst) begin
            x       <= '0;
            x_valid <= 1'b0;
            primed  <= 1'b0;
        end else begin
            x_valid <= pop;
            if (pop) begin
                x      <= mem[rd_ptr];
                primed <= 1'b1;
            end
        end
    end

    // Sticky error flags; a set condition in the same cycle beats clr_flags.
    always_ff @(posedge CLOCK_50) begin
        if (!rst) begin
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
            if (starved) begin
                underrun <= 1'b1;
            end else if (clr_flags) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sample_pacer_fifo.sv
// Bench for sample_pacer_fifo: directed vector table, hand-written corner sequences,
// and randomized traffic, all compared against a queue-based reference model.
// The model paces by counting clock edges since reset release, not by mimicking a divider.
module tb_sample_pacer_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int DIV   = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic             x_valid;
    logic [3:0]       level;
    logic             overflow;
    logic             underrun;
    logic             clr_flags;

    sample_pacer_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV(DIV)) dut (
        .CLOCK_50 (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .x_valid  (x_valid),
        .level    (level),
        .overflow (overflow),
        .underrun (underrun),
        .clr_flags(clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors   = 0;
    int n_checks = 0;

    // Reference model state
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_x;
    bit               m_xv, m_ovf, m_und, m_primed;
    int               m_edges;
    bit               model_ok = 0;

    // Observation helpers
    logic [WIDTH-1:0] xs[$];
    int               n_xv;
    int               max_lvl;

    typedef struct {
        logic             r, v, c;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] ex;
        logic             exv;
        logic [3:0]       elev;
        logic             erdy, eovf, eund;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input logic r, v, input logic [7:0] d, input logic c,
                                input logic [7:0] ex, input logic exv, input logic [3:0] elev,
                                input logic erdy, eovf, eund);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.c = c;
        t.ex = ex; t.exv = exv; t.elev = elev; t.erdy = erdy; t.eovf = eovf; t.eund = eund;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model over the edge, compare all outputs.
    task automatic step(input logic v, input logic [7:0] d, input logic c, input logic r);
        bit m_rdy, strobe, set_o, set_u;
        in_valid  = v;
        in_data   = d;
        clr_flags = c;
        rst       = r;
        m_rdy = (mq.size() < DEPTH);
        if (model_ok) chk("in_ready_pre", in_ready, m_rdy);
        @(posedge clk);
        if (!r) begin
            mq.delete();
            m_x = '0; m_xv = 0; m_ovf = 0; m_und = 0; m_primed = 0; m_edges = 0;
            model_ok = 1;
        end else begin
            strobe = ((m_edges % DIV) == DIV - 1);
            set_u = 0;
            m_xv  = 0;
            if (strobe) begin
                if (mq.size() > 0) begin
                    m_x = mq.pop_front();
                    m_xv = 1;
                    m_primed = 1;
                end else if (m_primed) begin
                    set_u = 1;
                end
            end
            set_o = v && !m_rdy;
            if (v && m_rdy) mq.push_back(d);
            if (c) begin m_ovf = 0; m_und = 0; end
            if (set_o) m_ovf = 1;
            if (set_u) m_und = 1;
            m_edges++;
        end
        #1;
        chk("x", x, m_x);
        chk("x_valid", x_valid, m_xv);
        chk("level", level, mq.size());
        chk("overflow", overflow, m_ovf);
        chk("underrun", underrun, m_und);
        if (x_valid === 1'b1) begin
            xs.push_back(x);
            n_xv++;
        end
        if (int'(level) > max_lvl) max_lvl = int'(level);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 1);
    endtask

    task automatic do_reset();
        step(0, 8'h00, 0, 0);
        xs.delete();
        n_xv = 0;
        max_lvl = 0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 100 && level != 0; k++) idle(1);
        chk(name, level, 0);
    endtask

    initial begin
        logic [7:0] exp_q[$];
        int         xv_before;
        bit         got;

        rst = 0; in_valid = 0; in_data = 0; clr_flags = 0;

        // Directed table: reset, four pushes paced out every 4 clocks, then an
        // empty strobe after priming raises underrun, and clr_flags clears it.
        tbl[0]  = mk(0,0,8'd0 ,0, 8'd0 ,0,4'd0,1,0,0);
        tbl[1]  = mk(1,1,8'd13,0, 8'd0 ,0,4'd1,1,0,0);
        tbl[2]  = mk(1,1,8'd20,0, 8'd0 ,0,4'd2,1,0,0);
        tbl[3]  = mk(1,1,8'd17,0, 8'd0 ,0,4'd3,1,0,0);
        tbl[4]  = mk(1,1,8'd12,0, 8'd13,1,4'd3,1,0,0);
        tbl[5]  = mk(1,0,8'd0 ,0, 8'd13,0,4'd3,1,0,0);
        tbl[6]  = mk(1,0,8'd0 ,0, 8'd13,0,4'd3,1,0,0);
        tbl[7]  = mk(1,0,8'd0 ,0, 8'd13,0,4'd3,1,0,0);
        tbl[8]  = mk(1,0,8'd0 ,0, 8'd20,1,4'd2,1,0,0);
        tbl[9]  = mk(1,0,8'd0 ,0, 8'd20,0,4'd2,1,0,0);
        tbl[10] = mk(1,0,8'd0 ,0, 8'd20,0,4'd2,1,0,0);
        tbl[11] = mk(1,0,8'd0 ,0, 8'd20,0,4'd2,1,0,0);
        tbl[12] = mk(1,0,8'd0 ,0, 8'd17,1,4'd1,1,0,0);
        tbl[13] = mk(1,0,8'd0 ,0, 8'd17,0,4'd1,1,0,0);
        tbl[14] = mk(1,0,8'd0 ,0, 8'd17,0,4'd1,1,0,0);
        tbl[15] = mk(1,0,8'd0 ,0, 8'd17,0,4'd1,1,0,0);
        tbl[16] = mk(1,0,8'd0 ,0, 8'd12,1,4'd0,1,0,0);
        tbl[17] = mk(1,0,8'd0 ,0, 8'd12,0,4'd0,1,0,0);
        tbl[18] = mk(1,0,8'd0 ,0, 8'd12,0,4'd0,1,0,0);
        tbl[19] = mk(1,0,8'd0 ,0, 8'd12,0,4'd0,1,0,0);
        tbl[20] = mk(1,0,8'd0 ,0, 8'd12,0,4'd0,1,0,1);
        tbl[21] = mk(1,0,8'd0 ,1, 8'd12,0,4'd0,1,0,0);

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].r);
            chk($sformatf("tbl%0d_x", i), x, tbl[i].ex);
            chk($sformatf("tbl%0d_xv", i), x_valid, tbl[i].exv);
            chk($sformatf("tbl%0d_level", i), level, tbl[i].elev);
            chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].erdy);
            chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].eovf);
            chk($sformatf("tbl%0d_und", i), underrun, tbl[i].eund);
        end

        // Overflow: push every cycle; FIFO fills at edge 10, edges 11,12,14 drop.
        do_reset();
        for (int i = 1; i <= 14; i++) begin
            step(1, 8'(i), 0, 1);
            if (i == 10) begin
                chk("ovf_full_level", level, 8);
                chk("ovf_full_ready", in_ready, 0);
                chk("ovf_not_yet", overflow, 0);
            end
            if (i == 11) chk("ovf_set", overflow, 1);
        end
        drain("ovf_drain");
        exp_q = '{8'd1,8'd2,8'd3,8'd4,8'd5,8'd6,8'd7,8'd8,8'd9,8'd10,8'd13};
        chk("ovf_count", xs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < xs.size(); i++)
            chk($sformatf("ovf_order%0d", i), xs[i], exp_q[i]);

        // Underrun only after priming.
        do_reset();
        idle(8);
        chk("und_unprimed", underrun, 0);
        step(1, 8'h5A, 0, 1);
        idle(11);
        chk("und_primed", underrun, 1);
        chk("und_x_hold", x, 8'h5A);

        // Paced stream: one push per strobe for 20 samples.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            idle(3);
            step(1, 8'(8'h40 + k), 0, 1);
        end
        idle(4);
        chk("pace_max_level", max_lvl <= 1, 1);
        chk("pace_count", n_xv, 20);
        chk("pace_ovf", overflow, 0);
        chk("pace_und", underrun, 0);
        for (int k = 0; k < 20 && k < xs.size(); k++)
            chk($sformatf("pace_seq%0d", k), xs[k], 8'(8'h40 + k));

        // Reset mid-operation discards buffered samples.
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 8'(8'h31 + i), 0, 1);
        chk("rst_pre_level", level, 5);
        chk("rst_pre_x", x, 8'h31);
        step(1, 8'hEE, 0, 0);
        chk("rst_level", level, 0);
        chk("rst_x", x, 0);
        chk("rst_flags", {overflow, underrun}, 0);
        xv_before = n_xv;
        idle(12);
        chk("rst_no_xv", n_xv, xv_before);
        step(1, 8'h77, 0, 1);
        got = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            idle(1);
            if (x_valid === 1'b1) got = 1;
        end
        chk("rst_new_xv", got, 1);
        chk("rst_new_x", x, 8'h77);

        // clr_flags in the same cycle as a dropped push: set wins.
        do_reset();
        for (int k = 0; k < 40 && in_ready !== 1'b0; k++) step(1, 8'(k), 0, 1);
        chk("clr_full", in_ready, 0);
        step(1, 8'hAA, 1, 1);
        chk("clr_set_wins", overflow, 1);
        step(0, 8'h00, 1, 1);
        chk("clr_clears", overflow, 0);

        // Randomized traffic with occasional clr and reset.
        do_reset();
        begin
            int dens;
            dens = 50;
            for (int i = 0; i < 3000; i++) begin
                if (i % 200 == 0) dens = $urandom_range(10, 95);
                step(($urandom % 100) < dens, 8'($urandom),
                     ($urandom % 40) == 0, ($urandom % 300) != 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
